// File: rtl/syn_pkg.sv
// syn_pkg: default widths, saturation limits and the clamp helper shared by the synaptic current driver.
package syn_pkg;
   localparam int ACC_W_DEF        = 12;
   localparam int CUR_W_DEF        = 8;
   localparam int W_W_DEF          = 8;
   localparam int DECAY_SHIFT_DEF  = 2;
   localparam int DECAY_PERIOD_DEF = 4;
   localparam int ACC_MAX          = 2**ACC_W_DEF - 1;
   localparam int CUR_MAX          = 2**CUR_W_DEF - 1;
   function automatic int clamp(input int v, input int hi);
      return v < 0 ? 0 : (v > hi ? hi : v);
   endfunction
endpackage

// File: rtl/syn_tick_gen.sv
// syn_tick_gen: prescaler counting 0..DECAY_PERIOD-1; dstep marks the last count of each period.
module syn_tick_gen #(
   parameter int DECAY_PERIOD = 4
) (
   input  logic clk,
   input  logic reset,
   output logic dstep
);
   localparam int PW = DECAY_PERIOD > 1 ? $clog2(DECAY_PERIOD) : 1;
   localparam logic [PW-1:0] LAST = PW'(DECAY_PERIOD - 1);
   logic [PW-1:0] cnt;
   assign dstep = cnt == LAST;
   always_ff @(posedge clk)
      if (reset) cnt <= '0;
      else       cnt <= dstep ? '0 : cnt + 1'b1;
endmodule

// File: rtl/syn_current_driver.sv
// syn_current_driver: spike events feed a decaying accumulator whose saturated value drives the neuron current.
// Define SYN_INHIB_EN to add the inhibitory event port pair (subtracted, floored at 0).
module syn_current_driver
   import syn_pkg::*;
#(
   parameter int ACC_W        = ACC_W_DEF,
   parameter int CUR_W        = CUR_W_DEF,
   parameter int W_W          = W_W_DEF,
   parameter int DECAY_SHIFT  = DECAY_SHIFT_DEF,
   parameter int DECAY_PERIOD = DECAY_PERIOD_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             spike_in,
   input  logic [W_W-1:0]   weight,
   input  logic             cnt_clr,
   output logic [CUR_W-1:0] current,
   output logic [7:0]       evt_cnt,
   output logic             tick
`ifdef SYN_INHIB_EN
   ,
   input  logic             inh_spike_in,
   input  logic [W_W-1:0]   inh_weight
`endif
);
   localparam int ACC_TOP = 2**ACC_W - 1;
   localparam int CUR_TOP = 2**CUR_W - 1;
   logic dstep, inh_v;
   logic [W_W-1:0] inh_w;
   logic [ACC_W-1:0] acc, shr, dec, a1, acc_next;
   logic signed [ACC_W+1:0] exc_t, inh_t, a2;
   logic [8:0] cnt_sum;
`ifdef SYN_INHIB_EN
   assign inh_v = inh_spike_in;
   assign inh_w = inh_weight;
`else
   assign inh_v = 1'b0;
   assign inh_w = '0;
`endif
   syn_tick_gen #(.DECAY_PERIOD(DECAY_PERIOD)) u_tick (.clk(clk), .reset(reset), .dstep(dstep));
   // Force a minimum decrement of 1 so small residues still drain to zero.
   assign shr      = acc >> DECAY_SHIFT;
   assign dec      = (shr == '0 && acc != '0) ? ACC_W'(1) : shr;
   assign a1       = dstep ? acc - dec : acc;
   assign exc_t    = spike_in ? {{(ACC_W+2-W_W){1'b0}}, weight} : '0;
   assign inh_t    = inh_v ? {{(ACC_W+2-W_W){1'b0}}, inh_w} : '0;
   assign a2       = $signed({2'b00, a1}) + exc_t - inh_t;
   assign acc_next = ACC_W'(clamp(int'(a2), ACC_TOP));
   assign cnt_sum  = {1'b0, evt_cnt} + 9'(spike_in) + 9'(inh_v);
   always_ff @(posedge clk)
      if (reset) begin
         acc     <= '0;
         current <= '0;
         evt_cnt <= '0;
         tick    <= 1'b0;
      end else begin
         acc     <= acc_next;
         current <= CUR_W'(clamp(int'(acc_next), CUR_TOP));
         evt_cnt <= cnt_clr ? 8'd0 : (cnt_sum > 9'd255 ? 8'd255 : cnt_sum[7:0]);
         tick    <= dstep;
      end
endmodule
